// File: rtl/apb4_cmd_queue.sv
// Command/response queue in front of an APB4 bus wrapper: FIFO'd commands issued one at a time, completions queued in order.
// Optional SLVERR counter enabled by defining APB4_CMDQ_ERR_CNT_EN (ERR_CNT is tied to 0 otherwise).
module apb4_cmd_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    CMD_VALID,
  output logic                    CMD_READY,
  input  logic                    CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [DATA_WIDTH/8-1:0] CMD_STRB,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_SLVERR,
  output logic                    RSP_WRITE,
  output logic                    TRANSFER,
  output logic                    WRITE,
  output logic [ADDR_WIDTH-1:0]   ADDR,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] STRB,
  input  logic                    READY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic                    SLVERR,
  output logic                    BUSY,
  output logic [7:0]              ERR_CNT
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CPW    = $clog2(CMD_DEPTH);
  localparam int RPW    = $clog2(RSP_DEPTH);
  localparam int CMD_W  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_W;
  localparam int RSP_W  = DATA_WIDTH + 2;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           state;
  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [RSP_W-1:0] rsp_mem [RSP_DEPTH];
  logic [CPW:0]     cmd_wr, cmd_rd;
  logic [RPW:0]     rsp_wr, rsp_rd;
  logic             cmd_empty, cmd_full, rsp_empty, rsp_full;
  logic             cmd_push, issue, done, rsp_pop;
  logic [RSP_W-1:0] rsp_head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign cmd_empty = (cmd_wr == cmd_rd);
  assign cmd_full  = (cmd_wr[CPW] != cmd_rd[CPW]) && (cmd_wr[CPW-1:0] == cmd_rd[CPW-1:0]);
  assign rsp_empty = (rsp_wr == rsp_rd);
  assign rsp_full  = (rsp_wr[RPW] != rsp_rd[RPW]) && (rsp_wr[RPW-1:0] == rsp_rd[RPW-1:0]);

  assign cmd_push = CMD_VALID && !cmd_full;
  assign issue    = (state == IDLE) && !cmd_empty && !rsp_full;
  assign done     = (state == ISSUE) && READY;
  assign rsp_pop  = !rsp_empty && RSP_READY;

  assign CMD_READY = !cmd_full;
  assign RSP_VALID = !rsp_empty;
  assign BUSY      = (state == ISSUE) || !cmd_empty || !rsp_empty;

  assign rsp_head = rsp_mem[rsp_rd[RPW-1:0]];
  assign RSP_RDATA  = rsp_empty ? '0   : rsp_head[RSP_W-1:2];
  assign RSP_SLVERR = rsp_empty ? 1'b0 : rsp_head[1];
  assign RSP_WRITE  = rsp_empty ? 1'b0 : rsp_head[0];

  // Storage arrays carry no reset; pointers alone define their contents.
  always_ff @(posedge PCLK) begin
    if (!PRESET && cmd_push)
      cmd_mem[cmd_wr[CPW-1:0]] <= {CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_STRB};
    if (!PRESET && done)
      rsp_mem[rsp_wr[RPW-1:0]] <= {(WRITE ? {DATA_WIDTH{1'b0}} : RDATA), SLVERR, WRITE};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      TRANSFER <= 1'b0;
      WRITE    <= 1'b0;
      ADDR     <= '0;
      WDATA    <= '0;
      STRB     <= '0;
      cmd_wr   <= '0;
      cmd_rd   <= '0;
      rsp_wr   <= '0;
      rsp_rd   <= '0;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + (CPW+1)'(1);
      if (issue)    cmd_rd <= cmd_rd + (CPW+1)'(1);
      if (done)     rsp_wr <= rsp_wr + (RPW+1)'(1);
      if (rsp_pop)  rsp_rd <= rsp_rd + (RPW+1)'(1);
      case (state)
        IDLE: if (issue) begin
          state    <= ISSUE;
          TRANSFER <= 1'b1;
          {WRITE, ADDR, WDATA, STRB} <= cmd_mem[cmd_rd[CPW-1:0]];
        end
        ISSUE: if (READY) begin
          state    <= IDLE;
          TRANSFER <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB4_CMDQ_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET)
      err_cnt <= '0;
    else if (done && SLVERR && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end

  assign ERR_CNT = err_cnt;
`else
  assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_apb4_cmd_queue.sv
// Bench for apb4_cmd_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_apb4_cmd_queue;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int CD = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr, rsp_write;
  logic          transfer, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] strb;
  logic          ready = 1'b0, slverr = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          busy;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  apb4_cmd_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_DEPTH(CD), .RSP_DEPTH(RD)) dut (
    .PCLK(clk), .PRESET(rst),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_STRB(cmd_strb),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
    .RSP_SLVERR(rsp_slverr), .RSP_WRITE(rsp_write),
    .TRANSFER(transfer), .WRITE(write), .ADDR(addr), .WDATA(wdata), .STRB(strb),
    .READY(ready), .RDATA(rdata), .SLVERR(slverr),
    .BUSY(busy), .ERR_CNT(err_cnt)
  );

  typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s;} cmd_t;
  typedef struct {logic [DW-1:0] r; logic e; logic w;} rsp_t;

  cmd_t cq[$];
  rsp_t rq[$];
  cmd_t cur;
  bit   fly = 0;
  int   errs = 0;
  int   popped = 0;
  int   checks = 0;
  int   fails = 0;

  // Reference: one pending command slot, a command queue and a response queue, advanced per clock.
  task automatic model_edge();
    int   cn, rn;
    cmd_t c;
    rsp_t x;
    cn = cq.size();
    rn = rq.size();
    if (rst) begin
      cq.delete(); rq.delete(); fly = 0; errs = 0;
      return;
    end
    if (rsp_ready && rn > 0) begin
      x = rq.pop_front();
      popped++;
    end
    if (fly) begin
      if (ready) begin
        x.r = cur.w ? '0 : rdata;
        x.e = slverr;
        x.w = cur.w;
        rq.push_back(x);
        if (slverr && errs < 255) errs++;
        fly = 0;
      end
    end else if (cn > 0 && rn < RD) begin
      cur = cq.pop_front();
      fly = 1;
    end
    if (cmd_valid && cn < CD) begin
      c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata; c.s = cmd_strb;
      cq.push_back(c);
    end
  endtask

  function automatic int exp_err();
`ifdef APB4_CMDQ_ERR_CNT_EN
    return errs;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("cmd_ready", 64'(cmd_ready), 64'(cq.size() < CD));
    chk("transfer", 64'(transfer), 64'(fly));
    if (fly) begin
      chk("write", 64'(write), 64'(cur.w));
      chk("addr", 64'(addr), 64'(cur.a));
      chk("wdata", 64'(wdata), 64'(cur.d));
      chk("strb", 64'(strb), 64'(cur.s));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(rq.size() > 0));
    if (rq.size() > 0) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(rq[0].r));
      chk("rsp_slverr", 64'(rsp_slverr), 64'(rq[0].e));
      chk("rsp_write", 64'(rsp_write), 64'(rq[0].w));
    end
    chk("busy", 64'(busy), 64'(fly || cq.size() > 0 || rq.size() > 0));
    chk("err_cnt", 64'(err_cnt), 64'(exp_err()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
  endtask

  initial begin
    int p0;
    int ee;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_transfer", 64'(transfer), 0);
    chk("rst_write", 64'(write), 0);
    chk("rst_addr", 64'(addr), 0);
    chk("rst_wdata", 64'(wdata), 0);
    chk("rst_strb", 64'(strb), 0);
    chk("rst_cmd_ready", 64'(cmd_ready), 1);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);

    // Single write, READY after two wait cycles
    push_cmd(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
    step();
    chk("wr_accept_transfer", 64'(transfer), 0);
    cmd_valid = 1'b0;
    step();
    chk("wr_transfer", 64'(transfer), 1);
    chk("wr_addr", 64'(addr), 64'h10);
    chk("wr_wdata", 64'(wdata), 64'hA5A5A5A5);
    step(); step();
    chk("wr_hold", 64'(transfer), 1);
    ready = 1'b1; rdata = 32'hDEADBEEF;
    step();
    ready = 1'b0;
    chk("wr_rsp_valid", 64'(rsp_valid), 1);
    chk("wr_rsp_write", 64'(rsp_write), 1);
    chk("wr_rsp_slverr", 64'(rsp_slverr), 0);
    chk("wr_rsp_rdata", 64'(rsp_rdata), 0);
    chk("wr_gap", 64'(transfer), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_popped", 64'(rsp_valid), 0);

    // Single read; WDATA/STRB still forwarded
    push_cmd(1'b0, 32'h10, 32'h0BADF00D, 4'h5);
    step();
    cmd_valid = 1'b0;
    step();
    chk("rd_wdata_fwd", 64'(wdata), 64'h0BADF00D);
    chk("rd_strb_fwd", 64'(strb), 64'h5);
    ready = 1'b1; rdata = 32'h12345678;
    step();
    ready = 1'b0;
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("rd_rsp_write", 64'(rsp_write), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Five back-to-back commands with READY low: 1 issued + 4 queued
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'(i % 2), AW'(32'h100 + i * 4), $urandom, SW'($urandom));
      step();
    end
    cmd_valid = 1'b0;
    chk("b2b_cmd_ready_low", 64'(cmd_ready), 0);
    p0 = popped;
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ready = (i % 3 == 0); rdata = $urandom;
      step();
    end
    ready = 1'b0;
    chk("b2b_all_responses", 64'(popped - p0), 5);
    chk("b2b_idle", 64'(busy), 0);

    // Response FIFO full stalls the fifth issue until one pop
    rsp_ready = 1'b0; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'b0, AW'(32'h200 + i * 4), $urandom, SW'($urandom));
      rdata = $urandom;
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rdata = $urandom;
      step();
    end
    chk("full_no_issue", 64'(transfer), 0);
    chk("full_rsp_valid", 64'(rsp_valid), 1);
    chk("full_rsp_count", 64'(rq.size()), 4);
    chk("full_busy", 64'(busy), 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("full_still_idle", 64'(transfer), 0);
    step();
    chk("full_issue_after_pop", 64'(transfer), 1);
    ready = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    ready = 1'b0; rsp_ready = 1'b0;

    // Reset while a transfer is outstanding; inputs ignored during reset
    push_cmd(1'b1, 32'h300, 32'h11112222, 4'h3);
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_transfer", 64'(transfer), 1);
    rst = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1; ready = 1'b1;
    step();
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; ready = 1'b0;
    chk("rst_mid_transfer", 64'(transfer), 0);
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_mid_busy", 64'(busy), 0);
    step();
    chk("rst_mid_no_accept", 64'(busy), 0);

    // Three SLVERR completions
    for (int k = 0; k < 3; k++) begin
      push_cmd(1'(k == 1), AW'(32'h400 + k), $urandom, SW'($urandom));
      step();
      cmd_valid = 1'b0;
      step();
      ready = 1'b1; slverr = 1'b1; rdata = $urandom;
      step();
      ready = 1'b0; slverr = 1'b0;
    end
    chk("err_head_slverr", 64'(rsp_slverr), 1);
`ifdef APB4_CMDQ_ERR_CNT_EN
    ee = 3;
`else
    ee = 0;
`endif
    chk("err_cnt_three", 64'(err_cnt), 64'(ee));
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rsp_ready = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = SW'($urandom);
      ready     = $urandom_range(0, 2) == 0;
      rdata     = $urandom;
      slverr    = 1'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      rst       = $urandom_range(0, 1499) == 0;
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
